load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory port: accepts one load/store per request from the CPU memory stage, converts it to aligned 32-bit word transactions with per-lane byte enables, and returns zero- or sign-extended load data. Accesses that cross a word boundary are split into two sequential word transactions. Sits between the execute/memory pipeline stage and the data memory, or a variable-latency memory wrapper.

## Interface
- No parameters. Data width 32 and lane count 4 are fixed.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  CPU request valid
- req_ready_o  out  1  unit idle, can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_addr_i  in  32  byte address, any alignment
- req_wdata_i  in  32  store data, right-aligned
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  32  extended load data; 0 for stores and errors
- resp_err_o  out  1  illegal funct3 for the direction; valid with resp_valid_o
- mem_req_o  out  1  word transaction request
- mem_ack_i  in  1  memory accepted/completed the transaction
- mem_addr_o  out  32  word-aligned byte address, [1:0] = 0
- mem_wr_en_o  out  1  store transaction
- mem_wr_data_o  out  32  lane-positioned write data
- mem_byte_en_o  out  4  lane enables, bit n = bits [8n+7:8n]
- mem_rd_data_i  in  32  read word, valid in the ack cycle

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
  - IDLE: req_ready_o = 1.
  - On req_valid_i, latch the request and go to ACC0. If funct3 is illegal, go to RESP with err instead. Stores accept only 000/001/010.
- Let off = addr[1:0]. Size mask: byte 0x1, half 0x3, word 0xF.
  - 8-bit be = mask << off; 64-bit wd = {32'b0, wdata} << 8*off.
  - Beat 0: addr & ~3, be[3:0], wd[31:0].
  - Beat 1: (addr & ~3) + 4, wrapping modulo 2^32; be[7:4], wd[63:32].
  - split = (be[7:4] != 0).
- ACC0/ACC1: mem_req_o = 1 and the beat's address, data and enables are held constant until mem_ack_i. On ack, capture mem_rd_data_i into beat register 0 or 1. After ACC0, go to ACC1 if split, else RESP. After ACC1, go to RESP.
- RESP: resp_valid_o = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- Load result: r = {beat1, beat0} >> 8*off. Take r[7:0] or r[15:0] or r[31:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - beat1 = 0 when not split.
- mem_ack_i is ignored while mem_req_o = 0.

## Timing
- Reset values: state IDLE, req_ready_o = 1, all other outputs 0, beat registers 0.
- Accept at edge N. ACC0 runs in cycle N+1, and mem_ack_i may be high in that same cycle.
  - Zero-wait aligned access: resp_valid_o in cycle N+2.
  - Zero-wait split access: resp_valid_o in cycle N+3.
  - Each wait cycle on the memory side adds one cycle.
- Back-to-back: the next request is accepted in the cycle after RESP.
- Reset asserted mid-transaction: the unit immediately returns to IDLE, mem_req_o drops, and the pending request is discarded with no response.

## Structure
- lsu_pkg:
  - state enum
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - size-mask function
- Sub-module lsu_align: purely combinational.
  - Store path: be/wd generation.
  - Load path: {beat1, beat0} shift and extension.
- load_store_unit holds the FSM, the request latch and the beat registers.

## Test plan
- SW 0xDEADBEEF to 0x100, ack immediate:
  - one beat, addr 0x100, be 0xF
  - resp_valid_o in cycle N+2, rdata 0
- LB from 0x103 with memory word 0x80000000:
  - be 0x8
  - rdata 0xFFFFFF80
  - LBU of the same address gives 0x00000080
- LW from 0x102, words 0x100 = 0x44332211 and 0x104 = 0x88776655:
  - two beats, be 0xC then 0x3
  - rdata 0x66554433
  - response in cycle N+3
- SH 0xBEEF to 0x107:
  - beat 0: addr 0x104, be 0x8, data 0xEF000000
  - beat 1: addr 0x108, be 0x1, data 0x000000BE
- LW from 0xFFFFFFFE: second beat addr 0x00000000. Also SW with funct3 = 100: no mem_req_o, resp_err_o = 1.
- Memory holds ack low for 3 cycles:
  - mem_addr_o, mem_wr_data_o and mem_byte_en_o are stable throughout
  - separately, rst_n pulsed during ACC1: mem_req_o drops asynchronously, no resp_valid_o, and req_ready_o = 1 after release

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and size helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Lane mask of the access size before it is shifted to the byte offset.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'h1;
      2'b01:   return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  // Stores have no unsigned variants; loads accept the five RV32I codes.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane positioning for stores and extraction/extension for loads
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_beat0,
  input  logic [31:0] i_beat1,
  output logic [7:0]  o_be,
  output logic [63:0] o_wd,
  output logic [31:0] o_rdata
);

  logic [63:0] w_rword;

  // Two-word view of the access: enables and data span beat0 (low) and beat1 (high).
  always_comb begin
    o_be    = {4'b0000, size_mask(i_funct3)} << i_off;
    o_wd    = {32'b0, i_wdata} << {i_off, 3'b000};
    w_rword = {i_beat1, i_beat0} >> {i_off, 3'b000};
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_rword[7]}}, w_rword[7:0]};
      F3_H:    o_rdata = {{16{w_rword[15]}}, w_rword[15:0]};
      F3_W:    o_rdata = w_rword[31:0];
      F3_BU:   o_rdata = {24'b0, w_rword[7:0]};
      F3_HU:   o_rdata = {16'b0, w_rword[15:0]};
      default: o_rdata = 32'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator splitting unaligned accesses into word beats
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_wr_data_o,
  output logic [3:0]  mem_byte_en_o,
  input  logic [31:0] mem_rd_data_i
);

  lsu_state_e  r_state, w_next;
  logic        r_we, r_err;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_wdata, r_beat0, r_beat1;

  logic [7:0]  w_be;
  logic [63:0] w_wd;
  logic [31:0] w_rdata, w_base;
  logic        w_split, w_mem_req, w_hi;

  assign w_base    = {r_addr[31:2], 2'b00};
  assign w_split   = |w_be[7:4];
  assign w_mem_req = (r_state == ST_ACC0) || (r_state == ST_ACC1);
  assign w_hi      = (r_state == ST_ACC1);

  lsu_align u_align (
    .i_funct3 (r_funct3),
    .i_off    (r_addr[1:0]),
    .i_wdata  (r_wdata),
    .i_beat0  (r_beat0),
    .i_beat1  (r_beat1),
    .o_be     (w_be),
    .o_wd     (w_wd),
    .o_rdata  (w_rdata)
  );

  // State register; reset drops any in-flight beat immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state: illegal requests skip the memory and go straight to the response.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid_i)
                 w_next = f3_legal(req_we_i, req_funct3_i) ? ST_ACC0 : ST_RESP;
      ST_ACC0: if (mem_ack_i) w_next = w_split ? ST_ACC1 : ST_RESP;
      ST_ACC1: if (mem_ack_i) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch and beat capture; beats are cleared on accept so an unsplit load sees beat1 = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'b0;
      r_wdata  <= 32'b0;
      r_beat0  <= 32'b0;
      r_beat1  <= 32'b0;
    end else if (r_state == ST_IDLE && req_valid_i) begin
      r_we     <= req_we_i;
      r_err    <= !f3_legal(req_we_i, req_funct3_i);
      r_funct3 <= req_funct3_i;
      r_addr   <= req_addr_i;
      r_wdata  <= req_wdata_i;
      r_beat0  <= 32'b0;
      r_beat1  <= 32'b0;
    end else if (r_state == ST_ACC0 && mem_ack_i) begin
      r_beat0  <= mem_rd_data_i;
    end else if (r_state == ST_ACC1 && mem_ack_i) begin
      r_beat1  <= mem_rd_data_i;
    end
  end

  assign req_ready_o   = (r_state == ST_IDLE);
  assign mem_req_o     = w_mem_req;
  assign mem_wr_en_o   = w_mem_req && r_we;
  assign mem_addr_o    = !w_mem_req ? 32'b0 : (w_hi ? w_base + 32'd4 : w_base);
  assign mem_byte_en_o = !w_mem_req ? 4'b0  : (w_hi ? w_be[7:4] : w_be[3:0]);
  assign mem_wr_data_o = !w_mem_req ? 32'b0 : (w_hi ? w_wd[63:32] : w_wd[31:0]);
  assign resp_valid_o  = (r_state == ST_RESP);
  assign resp_err_o    = (r_state == ST_RESP) && r_err;
  assign resp_rdata_o  = (r_state == ST_RESP && !r_we && !r_err) ? w_rdata : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector table and scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk, rst_n;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        resp_valid_o, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic        mem_req_o, mem_ack_i, mem_wr_en_o;
  logic [31:0] mem_addr_o, mem_wr_data_o, mem_rd_data_i;
  logic [3:0]  mem_byte_en_o;

  load_store_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_funct3_i  (req_funct3_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .resp_valid_o  (resp_valid_o),
    .resp_rdata_o  (resp_rdata_o),
    .resp_err_o    (resp_err_o),
    .mem_req_o     (mem_req_o),
    .mem_ack_i     (mem_ack_i),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_en_o   (mem_wr_en_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_byte_en_o (mem_byte_en_o),
    .mem_rd_data_i (mem_rd_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] d0;
    logic [31:0] d1;
    int          waits;
    int          nbeats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  vec_t  vecs[14];
  int    n_pass, n_tot;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", name, got, exp);
  endtask

  task automatic run(input int idx, input vec_t v);
    beat_t b;
    resp_t e;
    int cyc, wcnt, nb;
    logic [31:0] s_a, s_wd;
    logic [3:0] s_be;
    logic done;
    chk($sformatf("v%0d_ready", idx), 32'(req_ready_o), 32'd1);
    if (v.nbeats >= 1) beat_q.push_back('{v.a0, v.be0, v.wd0, v.we});
    if (v.nbeats >= 2) beat_q.push_back('{v.a1, v.be1, v.wd1, v.we});
    resp_q.push_back('{v.rdata, v.err, v.err ? 1 : 1 + v.nbeats * (1 + v.waits)});
    req_valid_i = 1'b1; req_we_i = v.we; req_funct3_i = v.f3;
    req_addr_i = v.addr; req_wdata_i = v.wdata; mem_ack_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    cyc = 1; wcnt = 0; nb = 0; done = 1'b0;
    s_a = '0; s_wd = '0; s_be = '0;
    while (!done && cyc < 60) begin
      mem_ack_i = 1'b0; mem_rd_data_i = 32'b0;
      if (mem_req_o) begin
        if (wcnt == 0) begin
          if (beat_q.size() == 0) begin
            chk($sformatf("v%0d_unexpected_beat", idx), 32'(mem_req_o), 32'd0);
          end else begin
            b = beat_q.pop_front();
            chk($sformatf("v%0d_b%0d_addr", idx, nb), mem_addr_o, b.a);
            chk($sformatf("v%0d_b%0d_be", idx, nb), 32'(mem_byte_en_o), 32'(b.be));
            chk($sformatf("v%0d_b%0d_wd", idx, nb), mem_wr_data_o, b.wd);
            chk($sformatf("v%0d_b%0d_we", idx, nb), 32'(mem_wr_en_o), 32'(b.we));
          end
          s_a = mem_addr_o; s_wd = mem_wr_data_o; s_be = mem_byte_en_o;
        end else begin
          chk($sformatf("v%0d_hold_addr", idx), mem_addr_o, s_a);
          chk($sformatf("v%0d_hold_wd", idx), mem_wr_data_o, s_wd);
          chk($sformatf("v%0d_hold_be", idx), 32'(mem_byte_en_o), 32'(s_be));
        end
        if (wcnt == v.waits) begin
          mem_ack_i = 1'b1;
          mem_rd_data_i = (nb == 0) ? v.d0 : v.d1;
          nb++; wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        mem_ack_i = 1'b1;
        mem_rd_data_i = 32'hFFFF_FFFF;
      end
      if (resp_valid_o) begin
        done = 1'b1;
        if (resp_q.size() != 0) begin
          e = resp_q.pop_front();
          chk($sformatf("v%0d_rdata", idx), resp_rdata_o, e.rdata);
          chk($sformatf("v%0d_err", idx), 32'(resp_err_o), 32'(e.err));
          chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(e.lat));
        end
      end
      @(negedge clk);
      cyc++;
      if (done) chk($sformatf("v%0d_one_cycle_resp", idx), 32'(resp_valid_o), 32'd0);
    end
    mem_ack_i = 1'b0;
    chk($sformatf("v%0d_resp_seen", idx), 32'(done), 32'd1);
  endtask

  initial begin
    logic seen;
    n_pass = 0; n_tot = 0;
    rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b0;
    req_addr_i = 32'b0; req_wdata_i = 32'b0; mem_ack_i = 1'b0; mem_rd_data_i = 32'b0;

    //          we    f3    addr          wdata         d0            d1            w  n  a0            be0   wd0           a1            be1   wd1           rdata         err
    vecs[0]  = '{1'b1, 3'd2, 32'h100,      32'hDEADBEEF, 32'h0,        32'h0,        0, 1, 32'h100,      4'hF, 32'hDEADBEEF, 32'h0,        4'h0, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'd0, 32'h103,      32'h0,        32'h80000000, 32'h0,        0, 1, 32'h100,      4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 3'd4, 32'h103,      32'h0,        32'h80000000, 32'h0,        0, 1, 32'h100,      4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00000080, 1'b0};
    vecs[3]  = '{1'b0, 3'd2, 32'h102,      32'h0,        32'h44332211, 32'h88776655, 0, 2, 32'h100,      4'hC, 32'h0,        32'h104,      4'h3, 32'h0,        32'h66554433, 1'b0};
    vecs[4]  = '{1'b1, 3'd1, 32'h107,      32'h0000BEEF, 32'h0,        32'h0,        0, 2, 32'h104,      4'h8, 32'hEF000000, 32'h108,      4'h1, 32'h000000BE, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 3'd2, 32'hFFFFFFFE, 32'h0,        32'hAABBCCDD, 32'h11223344, 0, 2, 32'hFFFFFFFC, 4'hC, 32'h0,        32'h0,        4'h3, 32'h0,        32'h3344AABB, 1'b0};
    vecs[6]  = '{1'b1, 3'd4, 32'h100,      32'h12345678, 32'h0,        32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b0, 3'd1, 32'h102,      32'h0,        32'h80017777, 32'h0,        0, 1, 32'h100,      4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[8]  = '{1'b0, 3'd5, 32'h103,      32'h0,        32'h12000000, 32'h000000FE, 0, 2, 32'h100,      4'h8, 32'h0,        32'h104,      4'h1, 32'h0,        32'h0000FE12, 1'b0};
    vecs[9]  = '{1'b0, 3'd2, 32'h100,      32'h0,        32'hCAFEF00D, 32'h0,        3, 1, 32'h100,      4'hF, 32'h0,        32'h0,        4'h0, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[10] = '{1'b1, 3'd2, 32'h105,      32'h11223344, 32'h0,        32'h0,        2, 2, 32'h104,      4'hE, 32'h22334400, 32'h108,      4'h1, 32'h00000011, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 3'd3, 32'h200,      32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b1, 3'd0, 32'h102,      32'hFFFFFFA5, 32'h0,        32'h0,        0, 1, 32'h100,      4'h4, 32'hFFA50000, 32'h0,        4'h0, 32'h0,        32'h0,        1'b0};
    vecs[13] = '{1'b0, 3'd0, 32'h101,      32'h0,        32'h00007F00, 32'h0,        0, 1, 32'h100,      4'h2, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000007F, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run(i, vecs[i]);

    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'd2; req_addr_i = 32'h102;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("mrst_acc0_req", 32'(mem_req_o), 32'd1);
    mem_ack_i = 1'b1; mem_rd_data_i = 32'h1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    chk("mrst_acc1_addr", mem_addr_o, 32'h104);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_async_drop", 32'(mem_req_o), 32'd0);
    chk("mrst_ready_in_reset", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid_o || mem_req_o) seen = 1'b1;
    end
    chk("mrst_no_activity", 32'(seen), 32'd0);
    chk("mrst_ready_after", 32'(req_ready_o), 32'd1);

    run(14, vecs[3]);

    chk("beat_q_drained", 32'(beat_q.size()), 32'd0);
    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
